// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: segment bit positions and the active-high hex glyph table.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Logical (active-high) "nothing lit"; pin polarity is applied by the driver.
    localparam logic [7:0] SEG_ALL_OFF = 8'h00;

    // Returns {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
        logic [6:0] g;
        case (hex)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Hex nibble + decimal point to active-high {dp,g,f,e,d,c,b,a}.
// Purely combinational, no latency; no flow control.
// No backpressure: output follows the inputs.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg               = SEG_ALL_OFF;
        seg[SEG_G:SEG_A]  = hex_glyph(hex);
        seg[SEG_DP]       = dp;
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with frame-synchronous double-buffered load, blanking, LZ suppression and PWM.
// Latency: an/sseg registered one clock after the prescaler/index state selecting them; new data shown after the next frame boundary.
// Backpressure: load_ready low while the pending buffer is full; freed at the frame boundary. Define SSEG_BLINK_EN for per-digit blink.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV_W      = 16,
    parameter int BRIGHT_W       = 3,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_W        = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_hex,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_blank,
`ifdef SSEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   load_blink,
`endif
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [7:0]            SEG_POL  = {8{SEG_ACTIVE_LOW != 0}};

    logic [CLK_DIV_W-1:0]    presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic [NUM_DIGITS-1:0]   lz_mask, lz_mask_nxt;
    logic                    pend_full;
    logic [BRIGHT_W-1:0]     bright_q, bright_eff;

    logic                    slot_start, slot_end, frame_end, xfer;
    logic                    lz_scan, digit_on, pwm_on, blink_phase;
    logic [3:0]              digit_hex;
    logic [NUM_DIGITS-1:0]   an_sel, an_nxt, act_blink;
    logic [7:0]              seg_lit;

    assign load_ready = !pend_full;
    assign xfer       = load_valid && load_ready;
    assign slot_start = (presc == '0);
    assign slot_end   = (presc == '1);
    assign frame_end  = slot_end && (idx == IDX_LAST);

    // Mask is built from the pending frame so it is ready on the copy edge.
    always_comb begin
        lz_mask_nxt = '0;
        lz_scan     = lz_suppress;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (lz_scan) begin
                if (pend_hex[4*i +: 4] != 4'h0 || pend_dp[i])
                    lz_scan = 1'b0;
                else if (!pend_blank[i])
                    lz_mask_nxt[i] = 1'b1;
            end
        end
    end

    // bright_q only updates on the slot's first edge, so that cycle uses the live input.
    assign bright_eff = slot_start ? brightness : bright_q;
    assign pwm_on     = (presc[CLK_DIV_W-1 -: BRIGHT_W] <= bright_eff);
    assign digit_hex  = act_hex[{idx, 2'b00} +: 4];
    assign digit_on   = !act_blank[idx] && !lz_mask[idx] && !(act_blink[idx] && blink_phase);

    always_comb begin
        an_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_sel[i] = (idx == IDX_W'(i));
        an_nxt = (digit_on && pwm_on) ? an_sel : '0;
    end

    sseg_hex_decode u_dec (
        .hex (digit_hex),
        .dp  (act_dp[idx]),
        .seg (seg_lit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            idx         <= '0;
            pend_hex    <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend_full   <= 1'b0;
            act_hex     <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            lz_mask     <= '0;
            bright_q    <= '0;
            an          <= AN_POL;
            sseg        <= SEG_ALL_OFF ^ SEG_POL;
            frame_start <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (slot_start)
                bright_q <= brightness;
            if (frame_end && pend_full) begin
                act_hex   <= pend_hex;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
                lz_mask   <= lz_mask_nxt;
                pend_full <= 1'b0;
            end
            // Never coincides with the copy above: xfer requires pend_full == 0.
            if (xfer) begin
                pend_hex   <= load_hex;
                pend_dp    <= load_dp;
                pend_blank <= load_blank;
                pend_full  <= 1'b1;
            end
            an          <= an_nxt ^ AN_POL;
            sseg        <= seg_lit ^ SEG_POL;
            frame_start <= slot_start && (idx == '0);
        end
    end

`ifdef SSEG_BLINK_EN
    logic [NUM_DIGITS-1:0] pend_blink, act_blink_q;
    logic [BLINK_W-1:0]    frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_blink  <= '0;
            act_blink_q <= '0;
            frame_cnt   <= '0;
        end else begin
            if (frame_end)
                frame_cnt <= frame_cnt + 1'b1;
            if (frame_end && pend_full)
                act_blink_q <= pend_blink;
            if (xfer)
                pend_blink <= load_blink;
        end
    end

    assign act_blink   = act_blink_q;
    assign blink_phase = frame_cnt[BLINK_W-1];
`else
    // Blink compiled out; BLINK_W only sizes the counter when it exists.
    assign act_blink   = '0;
    assign blink_phase = (BLINK_W == 0);
`endif

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized check of sseg_scan_ctrl (4 digits, 16-clock slots, active-low) against a frame-level reference model.
module tb_sseg_scan_ctrl;

    localparam int ND = 4;
    localparam int CW = 4;
    localparam int BW = 3;
    localparam int SLOT  = 1 << CW;
    localparam int FRAME = SLOT * ND;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [4*ND-1:0] load_hex;
    logic [ND-1:0] load_dp;
    logic [ND-1:0] load_blank;
    logic          lz_suppress;
    logic [BW-1:0] brightness;
    logic [ND-1:0] an;
    logic [7:0]    sseg;
    logic          frame_start;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .CLK_DIV_W      (CW),
        .BRIGHT_W       (BW),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1),
        .BLINK_W        (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_hex    (load_hex),
        .load_dp     (load_dp),
        .load_blank  (load_blank),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .an          (an),
        .sseg        (sseg),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  blank;
        bit          lz;
    } frame_t;

    frame_t      act;
    frame_t      pend_q[$];
    int unsigned c;
    int          bright_slot;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // A digit is hidden by LZ suppression if no higher digit is nonzero or carries a dp,
    // and it is itself a zero without dp.
    function automatic bit digit_visible(input frame_t f, input int d);
        bit leading;
        if (f.blank[d]) return 1'b0;
        if (d == 0)     return 1'b1;
        leading = f.lz;
        for (int i = ND - 1; i > d; i--)
            if (f.hex[4*i +: 4] != 4'h0 || f.dp[i]) leading = 1'b0;
        return !(leading && f.hex[4*d +: 4] == 4'h0 && !f.dp[d]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic frame_t dark_frame();
        frame_t f;
        f.hex = '0; f.dp = '0; f.blank = '1; f.lz = 1'b0;
        return f;
    endfunction

    // Called at a negedge with inputs already applied; advances one clock and checks outputs.
    task automatic tick();
        int p, d;
        bit lit, xfer, bnd, e_fs;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        frame_t f;
        if (reset) begin
            pend_q.delete();
            act = dark_frame();
            c = 0;
            bright_slot = 0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_an", an, 4'hF);
            chk("rst_sseg", sseg, 8'hFF);
            chk("rst_frame_start", frame_start, 0);
            chk("rst_ready", load_ready, 1);
            return;
        end
        chk("ready", load_ready, pend_q.size() == 0);
        p = int'(c % SLOT);
        d = int'((c / SLOT) % ND);
        if (p == 0) bright_slot = int'(brightness);
        lit   = digit_visible(act, d) && ((p * (1 << BW)) / SLOT) <= bright_slot;
        e_an  = lit ? ~(4'b0001 << d) : 4'hF;
        e_seg = ~{act.dp[d], glyph(act.hex[4*d +: 4])};
        e_fs  = (c % FRAME) == 0;
        xfer  = load_valid && pend_q.size() == 0;
        bnd   = (c % FRAME) == FRAME - 1;
        if (bnd && pend_q.size() > 0) begin
            act    = pend_q.pop_front();
            act.lz = lz_suppress;
        end
        if (xfer) begin
            f.hex = load_hex; f.dp = load_dp; f.blank = load_blank; f.lz = 1'b0;
            pend_q.push_back(f);
        end
        c++;
        @(posedge clk);
        @(negedge clk);
        chk("an", an, e_an);
        chk("frame_start", frame_start, e_fs);
        if (lit) chk("sseg", sseg, e_seg);
    endtask

    task automatic offer(input logic [15:0] hex, input logic [3:0] dp, input logic [3:0] blank, input int cycles);
        load_hex = hex; load_dp = dp; load_blank = blank; load_valid = 1'b1;
        repeat (cycles) tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_hex = '0; load_dp = '0; load_blank = '0;
        lz_suppress = 1'b0; brightness = 3'd7;
        act = dark_frame(); c = 0; bright_slot = 0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2 * FRAME) tick();

        offer(16'h1234, 4'h0, 4'h0, 1);
        repeat (FRAME + 80) tick();

        // Back-to-back: the second offer waits out the frame until the pending slot frees.
        offer(16'hA5C3, 4'h0, 4'h0, 1);
        offer(16'h9876, 4'h2, 4'h0, FRAME + 8);
        repeat (2 * FRAME) tick();

        lz_suppress = 1'b1;
        offer(16'h0045, 4'h0, 4'h0, 1);
        repeat (2 * FRAME) tick();
        offer(16'h0000, 4'h0, 4'h0, 1);
        repeat (2 * FRAME) tick();
        offer(16'h0F00, 4'h0, 4'h8, 1);
        repeat (2 * FRAME) tick();

        lz_suppress = 1'b0;
        brightness  = 3'd1;
        offer(16'hBEAD, 4'h1, 4'h0, 1);
        repeat (2 * FRAME) tick();
        brightness  = 3'd0;
        repeat (FRAME) tick();
        brightness  = 3'd7;

        // Reset mid-slot with the pending buffer full: that frame must never appear.
        while ((c % FRAME) != 10) tick();
        offer(16'h8888, 4'hF, 4'h0, 1);
        repeat (20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3 * FRAME) tick();

        for (int n = 0; n < 4000; n++) begin
            load_valid = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < ND; i++)
                load_hex[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            load_dp    = 4'($urandom & $urandom & $urandom);
            load_blank = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 7) == 0)   brightness  = 3'($urandom);
            if ($urandom_range(0, 299) == 0) lz_suppress = ~lz_suppress;
            tick();
        end
        load_valid = 1'b0;
        repeat (FRAME) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
